// File: rtl/f32m_mult_sched.sv
// rtl/f32m_mult_sched.sv - round-robin scheduler sharing one GF(3^2M) multiplier among N requesters
module f32m_mult_sched #(
    parameter int N         = 4,
    parameter int DW        = 388,
    parameter int START_CYC = 2,
    parameter int TMO       = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] a_in,
    input  logic [N*DW-1:0] b_in,
    output logic [N-1:0]    ack,
    output logic            err,
    output logic [DW-1:0]   c_out,
    output logic            busy,
    output logic            m_reset,
    output logic [DW-1:0]   m_a,
    output logic [DW-1:0]   m_b,
    input  logic [DW-1:0]   m_c,
    input  logic            m_done
);

    localparam int             PW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [2:0]     SC_LOAD  = 3'(START_CYC - 1);
    localparam logic [7:0]     TMO_LAST = 8'(TMO - 1);
    localparam logic [PW-1:0]  LAST_IDX = PW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_ACK} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [2:0]      scnt_q, scnt_d;
    logic [7:0]      tcnt_q, tcnt_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            err_q, err_d;
    logic [DW-1:0]   c_out_q, c_out_d;
    logic [DW-1:0]   m_a_q, m_a_d;
    logic [DW-1:0]   m_b_q, m_b_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic [DW-1:0]   sel_a, sel_b;
    logic            tmo_hit;

    // Scan from the highest offset down so the closest set bit after ptr is the last writer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (win_idx == PW'(i)) begin
                sel_a = a_in[i*DW +: DW];
                sel_b = b_in[i*DW +: DW];
            end
        end
    end

    assign tmo_hit = (tcnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            scnt_q  <= '0;
            tcnt_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            c_out_q <= '0;
            m_a_q   <= '0;
            m_b_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            scnt_q  <= scnt_d;
            tcnt_q  <= tcnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            c_out_q <= c_out_d;
            m_a_q   <= m_a_d;
            m_b_q   <= m_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_found) state_d = S_START;
            S_START: if (scnt_q == 3'd0) state_d = S_WAIT;
            S_WAIT:  if (m_done || tmo_hit) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ack/err are only ever set on the WAIT->ACK transition, so they pulse for exactly the ACK cycle.
    always_comb begin
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        scnt_d  = scnt_q;
        tcnt_d  = tcnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        c_out_d = c_out_q;
        m_a_d   = m_a_q;
        m_b_d   = m_b_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    m_a_d  = sel_a;
                    m_b_d  = sel_b;
                    gnt_d  = win_idx;
                    scnt_d = SC_LOAD;
                end
            end
            S_START: begin
                if (scnt_q == 3'd0) begin
                    tcnt_d = '0;
                end else begin
                    scnt_d = scnt_q - 3'd1;
                end
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + 8'd1;
                if (m_done) begin
                    c_out_d      = m_c;
                    ack_d[gnt_q] = 1'b1;
                end else if (tmo_hit) begin
                    c_out_d      = '0;
                    err_d        = 1'b1;
                    ack_d[gnt_q] = 1'b1;
                end
            end
            S_ACK: begin
                ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        m_reset = (state_q == S_IDLE) || (state_q == S_START);
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign c_out = c_out_q;
    assign m_a   = m_a_q;
    assign m_b   = m_b_q;

endmodule

// File: tb/tb_f32m_mult_sched.sv
// tb/tb_f32m_mult_sched.sv - directed self-checking bench for f32m_mult_sched with a mock xor multiplier
module tb_f32m_mult_sched;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int SC  = 2;
    localparam int TMO = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] a_in = '0;
    logic [N*DW-1:0] b_in = '0;
    logic [N-1:0]    ack;
    logic            err;
    logic [DW-1:0]   c_out;
    logic            busy;
    logic            m_reset;
    logic [DW-1:0]   m_a;
    logic [DW-1:0]   m_b;
    logic [DW-1:0]   m_c = '0;
    logic            m_done = 1'b0;

    logic            hang = 1'b0;
    logic [7:0]      mcnt = '0;

    int n_checks = 0;
    int n_errors = 0;

    f32m_mult_sched #(.N(N), .DW(DW), .START_CYC(SC), .TMO(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .ack     (ack),
        .err     (err),
        .c_out   (c_out),
        .busy    (busy),
        .m_reset (m_reset),
        .m_a     (m_a),
        .m_b     (m_b),
        .m_c     (m_c),
        .m_done  (m_done)
    );

    always #5 clk = ~clk;

    // Mock multiplier: done rises 10 cycles after m_reset falls, product is a^b.
    always @(posedge clk) begin
        if (m_reset) begin
            mcnt   <= '0;
            m_done <= 1'b0;
        end else if (!hang) begin
            if (mcnt == 8'd9) m_done <= 1'b1;
            else mcnt <= mcnt + 8'd1;
        end
        m_c <= m_a ^ m_b;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(output int n, output logic [N-1:0] a, output int mr_hi);
        logic seen_low;
        n = 0;
        a = '0;
        mr_hi = m_reset ? 1 : 0;
        seen_low = !m_reset;
        while (n < 200 && a == '0) begin
            @(negedge clk);
            n++;
            if (!m_reset) seen_low = 1'b1;
            else if (!seen_low) mr_hi++;
            a = ack;
        end
        if (a == '0) check("ack_timeout", 64'(n), 64'd0);
    endtask

    task automatic set_slice(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_in[i*DW +: DW] = a;
        b_in[i*DW +: DW] = b;
    endtask

    logic [N-1:0]  got_ack;
    logic [DW-1:0] exp_c [N];
    logic [N-1:0]  exp_ack [5];
    int lat;
    int mr;

    initial begin
        exp_c[0] = 16'h111E; exp_c[1] = 16'h22D2; exp_c[2] = 16'h3C33; exp_c[3] = 16'hB444;
        exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100;
        exp_ack[3] = 4'b1000; exp_ack[4] = 4'b0001;
        set_slice(0, 16'h0005, 16'h0003);
        set_slice(1, 16'h2222, 16'h00F0);
        set_slice(2, 16'h3333, 16'h0F00);
        set_slice(3, 16'h4444, 16'hF000);

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_c_out", 64'(c_out), 64'd0);
        check("rst_m_reset", 64'(m_reset), 64'd1);
        check("rst_m_a", 64'(m_a), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // single request
        req = 4'b0001;
        wait_ack(lat, got_ack, mr);
        check("single_ack", 64'(got_ack), 64'b0001);
        check("single_c_out", 64'(c_out), 64'h6);
        check("single_err", 64'(err), 64'd0);
        check("single_latency", 64'(lat), 64'd14);
        check("single_m_reset_cycles", 64'(mr), 64'(SC + 1));
        req = '0;
        @(negedge clk);
        check("single_ack_pulse", 64'(ack), 64'd0);
        check("single_c_hold", 64'(c_out), 64'h6);

        // fairness from ptr=0 with all requests held
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        set_slice(0, 16'h1111, 16'h000F);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(lat, got_ack, mr);
            check("rr_ack", 64'(got_ack), 64'(exp_ack[k]));
            check("rr_c_out", 64'(c_out), 64'(exp_c[k % N]));
        end
        req = '0;

        // pointer wrap: serve 3, then 0 wins over 3
        @(negedge clk);
        req = 4'b1000;
        wait_ack(lat, got_ack, mr);
        check("wrap_first", 64'(got_ack), 64'b1000);
        check("wrap_c_out", 64'(c_out), 64'hB444);
        req = 4'b1001;
        wait_ack(lat, got_ack, mr);
        check("wrap_next", 64'(got_ack), 64'b0001);
        req = '0;

        // operand stability
        @(negedge clk);
        set_slice(0, 16'h1234, 16'h00FF);
        req = 4'b0001;
        repeat (4) @(negedge clk);
        check("stab_in_wait", 64'({busy, m_reset}), 64'b10);
        a_in[0 +: DW] = 16'hFFFF;
        @(negedge clk);
        check("stab_m_a", 64'(m_a), 64'h1234);
        wait_ack(lat, got_ack, mr);
        check("stab_c_out", 64'(c_out), 64'h12CB);
        req = '0;
        a_in[0 +: DW] = 16'h1234;

        // timeout
        @(negedge clk);
        hang = 1'b1;
        req = 4'b0001;
        wait_ack(lat, got_ack, mr);
        check("tmo_ack", 64'(got_ack), 64'b0001);
        check("tmo_err", 64'(err), 64'd1);
        check("tmo_c_out", 64'(c_out), 64'd0);
        check("tmo_latency", 64'(lat), 64'(SC + TMO + 1));
        req = '0;
        @(negedge clk);
        check("tmo_err_pulse", 64'(err), 64'd0);
        hang = 1'b0;
        req = 4'b0010;
        wait_ack(lat, got_ack, mr);
        check("after_tmo_ack", 64'(got_ack), 64'b0010);
        check("after_tmo_err", 64'(err), 64'd0);
        check("after_tmo_c_out", 64'(c_out), 64'h22D2);
        req = '0;

        // async reset mid-WAIT
        @(negedge clk);
        req = 4'b0100;
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_ack", 64'(ack), 64'd0);
        check("arst_c_out", 64'(c_out), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("arst_no_ack", 64'(ack), 64'd0);
        end
        reset = 1'b1;
        wait_ack(lat, got_ack, mr);
        check("arst_ack_after", 64'(got_ack), 64'b0100);
        check("arst_c_after", 64'(c_out), 64'h3C33);
        check("arst_err_after", 64'(err), 64'd0);
        req = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/f32m_mult_sched.md
# f32m_mult_sched

Round-robin scheduler that shares one GF(3^{2M}) multiplier (`f32m_mult`) among N requesters in the pairing datapath. It arbitrates requests and latches the winner's operands into the multiplier. It sequences the multiplier's start/done protocol and returns the product to the winner with a one-cycle acknowledge. A watchdog flags a multiplier that never completes.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `DW`, 388: element width, `W2+1` for GF(3^{2M}) with M=97.
- `START_CYC`, 2: minimum cycles `m_reset` stays high after a grant (1..7).
- `TMO`, 255: WAIT-state watchdog limit in cycles (8-bit counter).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low; all state to reset values while low.
- `req`, in, N: level request per requester. Requester holds `req[i]`, `a_in` slice i and `b_in` slice i stable until it sees `ack[i]`.
- `a_in`, in, N*DW: operand A, requester i at bits [i*DW +: DW].
- `b_in`, in, N*DW: operand B, same packing.
- `ack`, out, N: registered one-cycle pulse, one-hot, to the served requester.
- `err`, out, 1: registered, high in the same cycle as `ack` when the operation timed out.
- `c_out`, out, DW: product. Valid while `ack` is high; held until the next `ack`.
- `busy`, out, 1: high whenever the state is not IDLE.
- `m_reset`, out, 1: active-high start/clear to the multiplier.
- `m_a`, out, DW: registered operand A to the multiplier.
- `m_b`, out, DW: registered operand B to the multiplier.
- `m_c`, in, DW: multiplier result.
- `m_done`, in, 1: multiplier done level.

## Operation
- States: IDLE, START, WAIT, ACK.
- IDLE: `m_reset`=1. If any `req` bit is set, the winner is the first set bit searching from `ptr`, `ptr+1`, … mod N.
  - Register `m_a`/`m_b` from the winner's slices and `gnt` = winner index.
  - Load `scnt` = START_CYC-1 and go to START.
  - With no requests, stay in IDLE.
- START: `m_reset`=1. Decrement `scnt`; at 0, go to WAIT and clear `tcnt`.
- WAIT: `m_reset`=0. `m_a`/`m_b` stay frozen. `tcnt` increments each cycle.
  - If `m_done`=1: `c_out` <= `m_c`, `err` <= 0, go to ACK.
  - Else if `tcnt`==TMO-1: `c_out` <= 0, `err` <= 1, go to ACK.
  - `m_done` wins if both conditions hold in the same cycle.
- ACK: `ack[gnt]`=1 and `err` as latched. `m_reset`=0. `ptr` <= (`gnt`+1) mod N. Go to IDLE.
- `ack`/`err` are 0 in every state except ACK.
- Requests arriving during START/WAIT/ACK wait for the next IDLE. `req` changes during service have no effect on the operation in flight.
- A requester must drop `req[i]` by the cycle after `ack[i]`. If `req[i]` is still high at the end of that IDLE cycle, it is treated as a new request.
- Reset values: state=IDLE, `ptr`=0, `gnt`=0, `ack`=0, `err`=0, `c_out`=0, `m_a`=0, `m_b`=0, `m_reset`=1, `busy`=0.
- Reset mid-operation: the operation is aborted with no `ack`. A still-asserted `req` is re-arbitrated starting from `ptr`=0 after `reset` releases.

## Timing
- Grant decision made in IDLE cycle t. START occupies t+1..t+START_CYC. WAIT starts at t+START_CYC+1.
- If `m_done` is first sampled high in WAIT cycle j (j=0 is the first WAIT cycle), `ack` is high at cycle t+START_CYC+2+j.
- The earliest next grant is in the IDLE cycle after ACK. Back-to-back service overhead is 3+START_CYC cycles plus the multiplier latency.
- Timeout: `ack`+`err` high at cycle t+START_CYC+TMO+1 of WAIT entry accounting, i.e. after TMO WAIT cycles.
- `m_done` is ignored outside WAIT. A stale `m_done`=1 cannot complete an op, because the multiplier clears `done` during START.

## Test plan
- Single request: N=4, mock multiplier (c=a^b, `done` 10 cycles after `m_reset` falls). `req`=0001, a=0x5, b=0x3 -> `ack`=0001 once, `c_out`=0x6, `err`=0; `m_reset` high exactly START_CYC+1 cycles including the IDLE grant cycle.
- Round-robin fairness: hold `req`=1111 continuously, re-raising each bit after its ack -> ack order 0001, 0010, 0100, 1000, 0001; no requester is served twice before all others are served.
- Pointer wrap: serve requester 3 first (`req`=1000), then assert `req`=1001 -> requester 0 is granted next.
- Timeout: mock never raises `done`, TMO=20 -> `ack`=0001 and `err`=1 after 20 WAIT cycles, `c_out`=0; the next request completes normally with `err`=0.
- Operand stability: change `a_in` slice 0 during WAIT -> `m_a` unchanged and the result uses the original operand.
- Async reset mid-WAIT: drive `reset` low between clock edges -> `busy`, `ack` and `c_out` go to 0 immediately; no `ack` is issued; after release with `req`=0100 held, requester 2 is served normally.
